// File: rtl/mic_window_ctrl.sv
// mic_window_ctrl
// Sequencing controller for the microphone volume meter. It derives a
// one-cycle sample strobe from the system clock and runs a fixed-length
// peak window over 12-bit mic samples. At the end of each window it
// publishes a 0-15 level and the window peak over a valid/ack handshake.
//
// Optional feature macro: MIC_PEAK_DECAY_EN
//   defined     : published level = max(raw level, previous level - 1),
//                 which gives peak-hold with a fall rate of one step per window
//   not defined : published level = raw level

module mic_window_ctrl #(
    parameter int SAMPLE_DIV = 5000,
    parameter int WINDOW     = 5000,
    parameter int THRESH     = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] mic_in,
    output logic        sample_stb,
    output logic [3:0]  level,
    output logic [11:0] peak,
    output logic        level_valid,
    input  logic        level_ack,
    output logic        overrun
);

    // Counter widths follow the parameter ranges; a 1-bit floor keeps the
    // declarations legal for the smallest allowed values.
    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(WINDOW - 1);
    localparam logic [11:0]   THRESH_V  = 12'(THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        PUB  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  presc;
    logic [IW-1:0]  idx;
    logic [11:0]    run_max;
    logic           take_sample;
    logic           publish;
    logic [3:0]     raw_level;
    logic [3:0]     new_level;
`ifdef MIC_PEAK_DECAY_EN
    logic [3:0]     held_level;
`endif

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the strobe and publish decodes. The strobe is a
    // pure decode of the prescaler, so it never depends on en directly; a
    // strobe that coincides with en=0 is simply not captured.
    always_comb begin
        state_next = state;
        sample_stb = 1'b0;
        publish    = 1'b0;
        if ((state != IDLE) && (presc == PRESC_MAX)) begin
            sample_stb = 1'b1;
        end
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = ACQ;
                end
            end
            ACQ: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (sample_stb && (idx == IDX_MAX)) begin
                    state_next = PUB;
                end
            end
            PUB: begin
                if (en) begin
                    publish    = 1'b1;
                    state_next = ACQ;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign take_sample = sample_stb & en;

    // Prescaler: held at zero while idle or disabled, otherwise free-running
    // through ACQ and PUB so the sample cadence is never stretched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if ((state == IDLE) || !en) begin
            presc <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Sample index within the window; disabling discards the partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if ((state == IDLE) || !en) begin
            idx <= '0;
        end else if (take_sample) begin
            if (idx == IDX_MAX) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Running peak: the first sample of a window replaces the old value, so
    // no separate clear is needed between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max <= '0;
        end else if (take_sample) begin
            if ((idx == '0) || (mic_in > run_max)) begin
                run_max <= mic_in;
            end
        end
    end

    // Level mapping from the window peak, with optional one-step-per-window decay.
    always_comb begin
        raw_level = 4'd0;
        if (run_max >= THRESH_V) begin
            raw_level = run_max[10:7];
        end
`ifdef MIC_PEAK_DECAY_EN
        held_level = (level == 4'd0) ? 4'd0 : (level - 4'd1);
        new_level  = (raw_level > held_level) ? raw_level : held_level;
`else
        new_level  = raw_level;
`endif
    end

    // Publish and handshake: a publish always loads new data and keeps valid
    // high; overrun flags a publish that lands on unacknowledged data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level       <= 4'd0;
            peak        <= 12'd0;
            level_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (publish) begin
            level       <= new_level;
            peak        <= run_max;
            level_valid <= 1'b1;
            if (level_valid && !level_ack) begin
                overrun <= 1'b1;
            end
        end else if (level_valid && level_ack) begin
            level_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mic_window_ctrl.sv
// tb_mic_window_ctrl
// Self-checking bench for mic_window_ctrl with SAMPLE_DIV=4, WINDOW=8.
// A cycle-level model built from sample queues and a cycle count is checked
// against the DUT on every falling edge; directed literal checks pin the model.

module tb_mic_window_ctrl;

    localparam int DIV = 4;
    localparam int WIN = 8;
    localparam int THR = 2048;

`ifdef MIC_PEAK_DECAY_EN
    localparam int L_W3 = 14;
    localparam int L_W4 = 13;
    localparam int L_RE = 12;
    localparam int L_R2 = 7;
`else
    localparam int L_W3 = 0;
    localparam int L_W4 = 5;
    localparam int L_RE = 1;
    localparam int L_R2 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [11:0] mic_in = 12'd0;
    logic        sample_stb;
    logic [3:0]  level;
    logic [11:0] peak;
    logic        level_valid;
    logic        level_ack = 1'b0;
    logic        overrun;

    int n_compared = 0;
    int n_mismatched = 0;
    int k = 0;
    logic [11:0] win [WIN];

    // model state
    bit m_active = 1'b0;
    int m_cyc = 0;
    int m_q[$];
    bit m_pub = 1'b0;
    int m_pend = 0;
    int m_level = 0;
    int m_peak = 0;
    bit m_valid = 1'b0;
    bit m_ovr = 1'b0;

    mic_window_ctrl #(
        .SAMPLE_DIV(DIV),
        .WINDOW(WIN),
        .THRESH(THR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mic_in(mic_in),
        .sample_stb(sample_stb),
        .level(level),
        .peak(peak),
        .level_valid(level_valid),
        .level_ack(level_ack),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic int expectLevel(input int pk, input int prev);
        int raw;
        raw = (pk >= THR) ? ((pk / 128) % 16) : 0;
`ifdef MIC_PEAK_DECAY_EN
        begin
            int held;
            held = (prev > 0) ? prev - 1 : 0;
            return (raw > held) ? raw : held;
        end
`else
        if (prev < 0) return 0;
        return raw;
`endif
    endfunction

    task automatic checkOutput(input string nm, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic ack_v);
        en = en_v;
        level_ack = ack_v;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        k++;
        mic_in = win[m_q.size() % WIN];
    endtask

    task automatic stepTo(input int target);
        while (k < target) stepCycle();
    endtask

    task automatic measureWindow(output int first_k, output int n_stb,
                                 output int last_k, output int valid_k);
        first_k = -1;
        n_stb = 0;
        last_k = -1;
        valid_k = -1;
        for (int i = 0; i < 60; i++) begin
            stepCycle();
            if (level_valid) begin
                valid_k = k;
                break;
            end
            if (sample_stb) begin
                if (first_k < 0) first_k = k;
                n_stb++;
                last_k = k;
            end
        end
    endtask

    task automatic setWindow(input logic [11:0] s0, input logic [11:0] s1,
                             input logic [11:0] s2, input logic [11:0] s3,
                             input logic [11:0] s4, input logic [11:0] s5,
                             input logic [11:0] s6, input logic [11:0] s7);
        win[0] = s0; win[1] = s1; win[2] = s2; win[3] = s3;
        win[4] = s4; win[5] = s5; win[6] = s6; win[7] = s7;
    endtask

    // Behavioural model: strobes fall every DIV-th cycle since the run started,
    // a window closes once WIN samples are queued, and publish happens the
    // cycle after that.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_cyc = 0;
            m_q.delete();
            m_pub = 1'b0;
            m_pend = 0;
            m_level = 0;
            m_peak = 0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end else begin
            bit stb_now;
            stb_now = m_active && ((m_cyc % DIV) == (DIV - 1));
            if (m_pub && en) begin
                if (m_valid && !level_ack) m_ovr = 1'b1;
                m_level = expectLevel(m_pend, m_level);
                m_peak = m_pend;
                m_valid = 1'b1;
            end else if (m_valid && level_ack) begin
                m_valid = 1'b0;
            end
            if (!en) begin
                m_active = 1'b0;
                m_cyc = 0;
                m_q.delete();
                m_pub = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_cyc = 0;
                m_pub = 1'b0;
            end else begin
                m_pub = 1'b0;
                if (stb_now) begin
                    m_q.push_back(int'(mic_in));
                    if (m_q.size() == WIN) begin
                        m_pend = 0;
                        foreach (m_q[i]) if (m_q[i] > m_pend) m_pend = m_q[i];
                        m_q.delete();
                        m_pub = 1'b1;
                    end
                end
                m_cyc++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        checkOutput("stb", int'(sample_stb),
                    int'(m_active && ((m_cyc % DIV) == (DIV - 1))));
        checkOutput("level", int'(level), m_level);
        checkOutput("peak", int'(peak), m_peak);
        checkOutput("valid", int'(level_valid), int'(m_valid));
        checkOutput("overrun", int'(overrun), int'(m_ovr));
    end

    initial begin
        int fk, ns, lk, vk;
        setWindow(12'h900, 12'h900, 12'h900, 12'h900,
                  12'h900, 12'h900, 12'h900, 12'h900);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_peak", int'(peak), 0);
        checkOutput("rst_valid", int'(level_valid), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] window 1: constant 0x900");
        applyStimulus(1'b1, 1'b0);
        k = 0;
        measureWindow(fk, ns, lk, vk);
        checkOutput("w1_first_stb", fk, 4);
        checkOutput("w1_stb_count", ns, 8);
        checkOutput("w1_last_stb", lk, 32);
        checkOutput("w1_valid_k", vk, 34);
        checkOutput("w1_peak", int'(peak), 12'h900);
        checkOutput("w1_level", int'(level), 2);
        setWindow(12'h100, 12'hFFF, 12'h800, 12'h000,
                  12'h000, 12'h000, 12'h000, 12'h000);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("ack_clears_valid", int'(level_valid), 0);

        $display("[TB] window 2: mixed samples, left unacknowledged");
        stepTo(66);
        checkOutput("w2_peak", int'(peak), 12'hFFF);
        checkOutput("w2_level", int'(level), 15);
        checkOutput("w2_valid", int'(level_valid), 1);
        checkOutput("w2_overrun", int'(overrun), 0);
        setWindow(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF,
                  12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);

        $display("[TB] window 3: below threshold, overwrites");
        stepTo(98);
        checkOutput("w3_peak", int'(peak), 12'h7FF);
        checkOutput("w3_level", int'(level), L_W3);
        checkOutput("w3_overrun", int'(overrun), 1);
        setWindow(12'h000, 12'hA80, 12'h123, 12'h555,
                  12'h9FF, 12'h200, 12'h000, 12'h007);

        $display("[TB] window 4: ack on the publish cycle");
        stepTo(129);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("w4_peak", int'(peak), 12'hA80);
        checkOutput("w4_level", int'(level), L_W4);
        checkOutput("w4_valid", int'(level_valid), 1);
        checkOutput("w4_overrun", int'(overrun), 1);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("w4_ack_clears", int'(level_valid), 0);

        $display("[TB] partial window then disable");
        setWindow(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                  12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        stepTo(150);
        applyStimulus(1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        repeat (4) stepCycle();
        checkOutput("idle_stb", int'(sample_stb), 0);
        checkOutput("idle_ack_ignored", int'(level_valid), 0);
        checkOutput("idle_peak_hold", int'(peak), 12'hA80);
        checkOutput("idle_level_hold", int'(level), L_W4);

        $display("[TB] re-enable: fresh window");
        setWindow(12'h100, 12'h200, 12'h880, 12'h100,
                  12'h000, 12'h000, 12'h000, 12'h000);
        applyStimulus(1'b1, 1'b0);
        k = 0;
        measureWindow(fk, ns, lk, vk);
        checkOutput("re_first_stb", fk, 4);
        checkOutput("re_stb_count", ns, 8);
        checkOutput("re_valid_k", vk, 34);
        checkOutput("re_peak", int'(peak), 12'h880);
        checkOutput("re_level", int'(level), L_RE);

        $display("[TB] asynchronous reset mid-window");
        stepTo(50);
        @(posedge clk);
        #2;
        rst = 1'b1;
        en = 1'b0;
        #1;
        checkOutput("arst_level", int'(level), 0);
        checkOutput("arst_peak", int'(peak), 0);
        checkOutput("arst_valid", int'(level_valid), 0);
        checkOutput("arst_overrun", int'(overrun), 0);
        checkOutput("arst_stb", int'(sample_stb), 0);
        @(negedge clk);
        rst = 1'b0;
        setWindow(12'hC00, 12'hC00, 12'hC00, 12'hC00,
                  12'hC00, 12'hC00, 12'hC00, 12'hC00);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        k = 0;
        measureWindow(fk, ns, lk, vk);
        checkOutput("r1_valid_k", vk, 34);
        checkOutput("r1_peak", int'(peak), 12'hC00);
        checkOutput("r1_level", int'(level), 8);
        checkOutput("r1_overrun", int'(overrun), 0);
        setWindow(12'h0A0, 12'h0A0, 12'h0A0, 12'h0A0,
                  12'h0A0, 12'h0A0, 12'h0A0, 12'h0A0);

        $display("[TB] post-reset window 2: ack on publish, no overrun");
        stepTo(65);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("r2_peak", int'(peak), 12'h0A0);
        checkOutput("r2_level", int'(level), L_R2);
        checkOutput("r2_valid", int'(level_valid), 1);
        checkOutput("r2_overrun", int'(overrun), 0);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("r2_ack_clears", int'(level_valid), 0);
        repeat (3) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
